mul_div_sequencer: RTL and testbench

//  Hardwired control FSM for the Phase-1 datapath. It replaces the bench-driven
//  T0..T6 control strobes for one instruction per start request:

---
 rtl/mul_div_sequencer_if.sv | 27 ++
 rtl/mul_div_sequencer.sv | 118 +++++++++++
 tb/tb_mul_div_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_sequencer_if.sv
// Control interface between the mul/div sequencer and the Phase-1 datapath:
// request/memory handshake and IR in, one-hot enables and strobes out.
interface mul_div_sequencer_if;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
  logic [15:0] Rout;
  logic [15:0] Rin;
  logic        PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin;
  logic        Zlowout, Zhighout, LOin, HIin;
  logic [4:0]  alu_op;
  logic        busy;
  logic        done;
  logic        illegal;

  modport master (
    output start, mem_ready, ir,
    input  Rout, Rin, PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin,
    input  Zlowout, Zhighout, LOin, HIin, alu_op, busy, done, illegal
  );

  modport slave (
    input  start, mem_ready, ir,
    output Rout, Rin, PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin, Yin, Zin,
    output Zlowout, Zhighout, LOin, HIin, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/mul_div_sequencer.sv
// Hardwired fetch/execute control FSM: fetch (T0-T2), decode (T3), then either
// a 3-register ALU op or a MUL/DIV that writes LO then HI.
module mul_div_sequencer #(
  parameter logic [4:0] OP_MUL    = 5'd15,
  parameter logic [4:0] OP_DIV    = 5'd16,
  parameter logic [4:0] OP_ALU_LO = 5'd0,
  parameter logic [4:0] OP_ALU_HI = 5'd12
) (
  input logic             clock,
  input logic             clear,
  mul_div_sequencer_if.slave sq
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  state_t     state_reg, state_next;
  logic [4:0] op, op_off;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_md;
  logic       unused_ir_bits;

  assign op  = sq.ir[31:27];
  assign ra  = sq.ir[26:23];
  assign rb  = sq.ir[22:19];
  assign rc  = sq.ir[18:15];
  assign unused_ir_bits = ^sq.ir[14:0];

  // Offset compare keeps the range check valid even when the group starts at 0.
  assign op_off = op - OP_ALU_LO;
  assign is_alu = (op_off <= 5'(OP_ALU_HI - OP_ALU_LO));
  assign is_md  = (op == OP_MUL) || (op == OP_DIV);

  always_ff @(posedge clock) begin
    if (!clear) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    sq.Rout     = '0;
    sq.Rin      = '0;
    sq.PCout    = 1'b0;
    sq.IncPC    = 1'b0;
    sq.MARin    = 1'b0;
    sq.memRead  = 1'b0;
    sq.MDRin    = 1'b0;
    sq.MDRout   = 1'b0;
    sq.IRin     = 1'b0;
    sq.Yin      = 1'b0;
    sq.Zin      = 1'b0;
    sq.Zlowout  = 1'b0;
    sq.Zhighout = 1'b0;
    sq.LOin     = 1'b0;
    sq.HIin     = 1'b0;
    sq.alu_op   = '0;
    sq.busy     = (state_reg != S_IDLE);
    sq.done     = 1'b0;
    sq.illegal  = 1'b0;

    case (state_reg)
      S_IDLE: if (sq.start) state_next = S_T0;
      S_T0: begin
        sq.PCout = 1'b1;
        sq.MARin = 1'b1;
        sq.IncPC = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        sq.memRead = 1'b1;
        sq.MDRin   = 1'b1;
        if (sq.mem_ready) state_next = S_T2;
      end
      S_T2: begin
        sq.MDRout = 1'b1;
        sq.IRin   = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        if (is_alu || is_md) begin
          sq.Rout = 16'd1 << ra;
          sq.Yin  = 1'b1;
          state_next = S_T4;
        end else begin
          sq.illegal = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_T4: begin
        sq.Rout   = 16'd1 << rb;
        sq.Zin    = 1'b1;
        sq.alu_op = op;
        state_next = S_T5;
      end
      S_T5: begin
        sq.Zlowout = 1'b1;
        // T3 already rejected everything else, so not-MUL/DIV means ALU group.
        if (is_md) begin
          sq.LOin = 1'b1;
          state_next = S_T6;
        end else begin
          sq.Rin  = 16'd1 << rc;
          sq.done = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_T6: begin
        sq.Zhighout = 1'b1;
        sq.HIin     = 1'b1;
        sq.done     = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Bench: sequencer driving a small behavioural datapath (regfile, Y, Z, HI/LO),
// table of instructions scored through an expectation queue, plus corner sequences.
module tb_mul_div_sequencer;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  mul_div_sequencer_if sq_if ();

  mul_div_sequencer dut (
    .clock (clock),
    .clear (clear),
    .sq    (sq_if)
  );

  // ---------------- behavioural datapath ----------------
  logic [31:0] regs [16];
  logic [31:0] y_reg, pc, mdr, ir_reg, lo, hi, mem_data, bus_val;
  logic [63:0] z_reg;
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [31:0] pre_data;

  assign sq_if.ir = ir_reg;

  function automatic logic [63:0] alu_f(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (f)
      5'd15:   alu_f = 64'(sa * sb);
      5'd16:   alu_f = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      5'd3:    alu_f = {32'd0, a + b};
      5'd4:    alu_f = {32'd0, a - b};
      5'd5:    alu_f = {32'd0, a & b};
      5'd6:    alu_f = {32'd0, a | b};
      default: alu_f = {32'd0, a ^ b};
    endcase
  endfunction

  always_comb begin
    bus_val = '0;
    if (sq_if.PCout)         bus_val = pc;
    else if (sq_if.MDRout)   bus_val = mdr;
    else if (sq_if.Zlowout)  bus_val = z_reg[31:0];
    else if (sq_if.Zhighout) bus_val = z_reg[63:32];
    else
      for (int i = 0; i < 16; i++)
        if (sq_if.Rout[i]) bus_val = regs[i];
  end

  always @(posedge clock) begin
    if (pre_we) regs[pre_addr] <= pre_data;
    for (int i = 0; i < 16; i++)
      if (sq_if.Rin[i]) regs[i] <= bus_val;
    if (sq_if.Yin)   y_reg  <= bus_val;
    if (sq_if.Zin)   z_reg  <= alu_f(sq_if.alu_op, y_reg, bus_val);
    if (sq_if.LOin)  lo     <= bus_val;
    if (sq_if.HIin)  hi     <= bus_val;
    if (sq_if.IncPC) pc     <= pc + 32'd1;
    if (sq_if.MDRin) mdr    <= mem_data;
    if (sq_if.IRin)  ir_reg <= bus_val;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  int txn = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    all_out = {11'd0, sq_if.Rout, sq_if.Rin, sq_if.PCout, sq_if.IncPC, sq_if.MARin,
               sq_if.memRead, sq_if.MDRin, sq_if.MDRout, sq_if.IRin, sq_if.Yin, sq_if.Zin,
               sq_if.Zlowout, sq_if.Zhighout, sq_if.LOin, sq_if.HIin, sq_if.alu_op,
               sq_if.busy, sq_if.done, sq_if.illegal};
  endfunction

  // Bus exclusivity and one-hot enables, checked on every sampled cycle.
  task automatic chk_bus();
    int ndrv;
    ndrv = int'(sq_if.PCout) + int'(sq_if.MDRout) + int'(sq_if.Rout != 0) +
           int'(sq_if.Zlowout) + int'(sq_if.Zhighout);
    chk("bus_excl", 64'(ndrv <= 1), 64'd1);
    chk("onehot", 64'($onehot0(sq_if.Rout) && $onehot0(sq_if.Rin)), 64'd1);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] o, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    mk_ir = {o, a, b, c, 15'd0};
  endfunction

  task automatic preload(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  // kind: 0 = ALU group, 1 = MUL/DIV, 2 = illegal
  typedef struct {
    logic [31:0] ir;
    logic [31:0] a, b;
    logic [31:0] res, lo, hi;
    int          kind;
    int          waits;
    bit          toggle;
  } vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    int          kind;
    int          lat;
    logic [31:0] res, lo, hi;
  } exp_t;

  exp_t sb[$];

  task automatic run_vec(input vec_t v);
    exp_t e, g;
    int cyc, rd, end_cyc, n_rd, y_cnt, z_cnt, rin_cnt, hi_cnt, done_cnt, ill_cnt;
    logic [15:0] rout_a, rout_b, rin_seen;
    logic [4:0]  aop;
    bit fin;
    preload(v.ir[26:23], v.a);
    preload(v.ir[22:19], v.b);
    e.op = v.ir[31:27]; e.ra = v.ir[26:23]; e.rb = v.ir[22:19]; e.rc = v.ir[18:15];
    e.kind = v.kind; e.res = v.res; e.lo = v.lo; e.hi = v.hi;
    e.lat = (v.kind == 0 ? 6 : v.kind == 1 ? 7 : 4) + v.waits;
    sb.push_back(e);
    @(negedge clock);
    mem_data = v.ir; sq_if.mem_ready = 1'b0; sq_if.start = 1'b1;
    cyc = 0; rd = 0; end_cyc = 0; n_rd = 0; y_cnt = 0; z_cnt = 0; rin_cnt = 0;
    hi_cnt = 0; done_cnt = 0; ill_cnt = 0; rout_a = '0; rout_b = '0; rin_seen = '0;
    aop = '0; fin = 1'b0;
    while (!fin && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (!v.toggle) sq_if.start = 1'b0;
      chk_bus();
      if (sq_if.memRead) begin
        n_rd++;
        sq_if.mem_ready = (rd >= v.waits);
        rd++;
      end else sq_if.mem_ready = 1'b0;
      if (sq_if.Yin) begin y_cnt++; rout_a = sq_if.Rout; end
      if (sq_if.Zin) begin z_cnt++; rout_b = sq_if.Rout; aop = sq_if.alu_op; end
      if (sq_if.Rin != 0) begin rin_cnt++; rin_seen = sq_if.Rin; end
      if (sq_if.HIin) hi_cnt++;
      if (sq_if.done) begin done_cnt++; end_cyc = cyc; fin = 1'b1; end
      if (sq_if.illegal) begin ill_cnt++; end_cyc = cyc; fin = 1'b1; end
      if (v.toggle) sq_if.start = (cyc % 2 == 1);
    end
    sq_if.start = 1'b0;
    sq_if.mem_ready = 1'b0;
    @(posedge clock);
    #1;
    g = sb.pop_front();
    txn++;
    $display("txn %0d op=%0d ra=%0d rb=%0d rc=%0d kind=%0d end_cycle=%0d", txn, g.op, g.ra,
             g.rb, g.rc, g.kind, end_cyc);
    chk("finished", 64'(fin), 64'd1);
    chk("latency", 64'(end_cyc), 64'(g.lat));
    chk("memread_cycles", 64'(n_rd), 64'(v.waits + 1));
    if (g.kind == 2) begin
      chk("illegal_pulse", 64'(ill_cnt), 64'd1);
      chk("no_exec_strobes", 64'(y_cnt + z_cnt + rin_cnt + done_cnt), 64'd0);
    end else begin
      chk("done_pulse", 64'(done_cnt), 64'd1);
      chk("no_illegal", 64'(ill_cnt), 64'd0);
      chk("rout_ra", 64'(rout_a), 64'(16'd1 << g.ra));
      chk("rout_rb", 64'(rout_b), 64'(16'd1 << g.rb));
      chk("alu_op", 64'(aop), 64'(g.op));
      if (g.kind == 0) begin
        chk("rin_rc", 64'(rin_seen), 64'(16'd1 << g.rc));
        chk("rc_value", 64'(regs[g.rc]), 64'(g.res));
        chk("no_hiin", 64'(hi_cnt), 64'd0);
      end else begin
        chk("lo_value", 64'(lo), 64'(g.lo));
        chk("hi_value", 64'(hi), 64'(g.hi));
        chk("no_rin", 64'(rin_cnt), 64'd0);
      end
    end
    // No queued instruction: the sequencer must stay idle with start low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_after", 64'(sq_if.busy), 64'd0);
    end
  endtask

  vec_t vt [10];

  initial begin
    logic [31:0] lo_before, hi_before;
    int cyc;
    bit seen;
    sq_if.start = 1'b0; sq_if.mem_ready = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0; mem_data = '0;
    pc = '0; mdr = '0; ir_reg = '0; y_reg = '0; z_reg = '0; lo = '0; hi = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;

    vt[0] = '{mk_ir(15, 4, 5, 0), 32'd21, -32'sd3, 0, 32'hFFFF_FFC1, 32'hFFFF_FFFF, 1, 0, 0};
    vt[1] = '{mk_ir(16, 4, 5, 0), 32'd21, -32'sd3, 0, 32'hFFFF_FFF9, 32'h0, 1, 0, 0};
    vt[2] = '{mk_ir(3, 2, 3, 1), 32'd10, 32'd32, 32'd42, 0, 0, 0, 0, 0};
    vt[3] = '{mk_ir(15, 6, 7, 0), 32'd100000, 32'd100000, 0, 32'h540B_E400, 32'h2, 1, 3, 0};
    vt[4] = '{mk_ir(4, 9, 10, 9), 32'd5, 32'd12, 32'hFFFF_FFF9, 0, 0, 0, 1, 0};
    vt[5] = '{mk_ir(12, 1, 2, 3), 32'hF0F0, 32'h0FF0, 32'hFF00, 0, 0, 0, 0, 0};
    vt[6] = '{mk_ir(0, 14, 15, 0), 32'd3, 32'd5, 32'd6, 0, 0, 0, 2, 0};
    vt[7] = '{mk_ir(16, 8, 11, 12), 32'd22, -32'sd3, 0, 32'hFFFF_FFF9, 32'h1, 1, 0, 1};
    vt[8] = '{mk_ir(13, 1, 2, 3), 32'd1, 32'd2, 0, 0, 0, 2, 0, 0};
    vt[9] = '{mk_ir(31, 1, 2, 3), 32'd1, 32'd2, 0, 0, 0, 2, 1, 1};

    // Reset: everything low, start ignored while clear is asserted.
    sq_if.start = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_outputs", all_out(), 64'd0);
    sq_if.start = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    chk("idle_after_reset", all_out(), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Clear during T4 of a MUL: outputs drop next cycle, HI/LO untouched.
    preload(4'd4, 32'd21);
    preload(4'd5, -32'sd3);
    lo_before = lo; hi_before = hi;
    @(negedge clock);
    mem_data = mk_ir(15, 4, 5, 0); sq_if.start = 1'b1; sq_if.mem_ready = 1'b1;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 30) begin
      @(negedge clock);
      cyc++;
      sq_if.start = 1'b0;
      if (sq_if.Zin) seen = 1'b1;
    end
    chk("reached_t4", 64'(seen), 64'd1);
    clear = 1'b0;
    @(negedge clock);
    chk("clear_mid_outputs", all_out(), 64'd0);
    clear = 1'b1;
    repeat (4) @(negedge clock);
    chk("clear_stays_idle", 64'(sq_if.busy), 64'd0);
    chk("clear_lo_kept", 64'(lo), 64'(lo_before));
    chk("clear_hi_kept", 64'(hi), 64'(hi_before));
    $display("txn %0d clear during T4 of MUL", ++txn);

    // Back-to-back with start held: done, one IDLE cycle, then T0.
    preload(4'd2, 32'hFF00);
    preload(4'd3, 32'h0FF0);
    @(negedge clock);
    mem_data = mk_ir(5, 2, 3, 7); sq_if.start = 1'b1; sq_if.mem_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 6) chk("b2b_done_c6", 64'(sq_if.done), 64'd1);
      if (c == 7) chk("b2b_idle_c7", 64'(sq_if.busy), 64'd0);
      if (c == 8) chk("b2b_t0_c8", 64'(sq_if.PCout && sq_if.busy), 64'd1);
    end
    sq_if.start = 1'b0;
    seen = 1'b0; cyc = 8;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (sq_if.done) seen = 1'b1;
    end
    chk("b2b_second_done", 64'(cyc), 64'd13);
    @(posedge clock);
    #1;
    chk("b2b_result", 64'(regs[7]), 64'h0F00);
    $display("txn %0d back-to-back AND with start held", ++txn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
